// File: rtl/bin_to_gray_stream.sv
// bin_to_gray_stream
//   Streaming binary-to-Gray encoder with a registered valid/ready output.
//   Words are Gray-encoded as they are accepted; an output register (OUT) plus a
//   one-entry skid register (SKD) give 1-cycle latency at full throughput while
//   keeping din_ready a flop. dout_step flags codes that differ from the last
//   transferred code in exactly one bit (the property async-FIFO pointers need).
//   Optional feature: define BIN2GRAY_PARITY_EN to add dout_parity (= ^dout).
module bin_to_gray_stream #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_step
`ifdef BIN2GRAY_PARITY_EN
  ,
  output logic                  dout_parity
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [DATA_WIDTH-1:0] W_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] skd_q, skd_d;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  last_vld_q;
  logic                  din_ready_q;

  logic                  in_xfer, out_xfer;
  logic [DATA_WIDTH-1:0] din_gray;
  logic [DATA_WIDTH-1:0] diff;
  logic                  one_hot;

  // Encoding is done at the input so both storage entries only ever hold Gray codes.
  assign din_gray = din ^ (din >> 1);

  assign din_ready  = din_ready_q;
  assign dout_valid = (state_q != ST_EMPTY);
  assign dout       = out_q;

  assign in_xfer  = din_valid & din_ready_q;
  assign out_xfer = dout_valid & dout_ready;

  // Exactly-one-bit test: nonzero and clearing the lowest set bit leaves nothing.
  assign diff      = out_q ^ last_q;
  assign one_hot   = (diff != '0) && ((diff & (diff - W_ONE)) == '0);
  assign dout_step = dout_valid & last_vld_q & one_hot;

`ifdef BIN2GRAY_PARITY_EN
  // Parity of a Gray code equals the LSB of the binary word it came from.
  assign dout_parity = ^out_q;
`endif

  // Next-state for the OUT/SKD pair; SKD is only loaded when OUT is occupied and stalled.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_d   = din_gray;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({in_xfer, out_xfer})
          2'b11: out_d = din_gray;
          2'b10: begin
            skd_d   = din_gray;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (out_xfer) begin
          out_d   = skd_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Storage, registered ready and last-transferred-code tracking; reset discards any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skd_q       <= '0;
      last_q      <= '0;
      last_vld_q  <= 1'b0;
      din_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skd_q       <= skd_d;
      din_ready_q <= (state_d != ST_FULL);
      if (out_xfer) begin
        last_q     <= out_q;
        last_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_gray_stream.sv
// Scoreboard bench for bin_to_gray_stream at DATA_WIDTH=4.
// Accepted words are pushed (Gray-encoded by the bench) into a queue; the head is
// compared against dout whenever dout_valid, and dout_step against a model of the
// last transferred code. Directed constant checks cover the documented scenarios.
module tb_bin_to_gray_stream;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_step;
`ifdef BIN2GRAY_PARITY_EN
  logic         dout_parity;
`endif

  bin_to_gray_stream #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_step  (dout_step)
`ifdef BIN2GRAY_PARITY_EN
    ,
    .dout_parity(dout_parity)
`endif
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] m_last;
  logic         m_last_vld;
  logic         post_rst;

  function automatic logic [W-1:0] gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++)
      g[i] = (i == W-1) ? b[i] : (b[i] ^ b[i+1]);
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // One clock: drive inputs, check outputs against the scoreboard at the falling
  // edge, then commit the handshakes the coming rising edge will perform.
  task automatic step_cyc(input logic [W-1:0] d, input logic dv, input logic dr, input logic rst);
    logic [W-1:0] head;
    logic         exp_step;
    din = d; din_valid = dv; dout_ready = dr; reset = rst;
    @(negedge clk);
    chk("dout_valid", 32'(dout_valid), 32'(sb_q.size() != 0));
    chk("din_ready", 32'(din_ready), 32'(sb_q.size() < 2));
    if (post_rst) begin
      chk("rst_dout", 32'(dout), 32'd0);
      post_rst = 1'b0;
    end
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      exp_step = m_last_vld && ($countones(head ^ m_last) == 1);
      chk("dout", 32'(dout), 32'(head));
      chk("dout_step", 32'(dout_step), 32'(exp_step));
`ifdef BIN2GRAY_PARITY_EN
      chk("parity", 32'(dout_parity), 32'(^head));
`endif
    end else begin
      chk("step_idle", 32'(dout_step), 32'd0);
    end
    if (rst) begin
      sb_q.delete();
      m_last_vld = 1'b0;
      m_last = '0;
      post_rst = 1'b1;
    end else begin
      if (dout_valid && dout_ready) begin
        m_last = sb_q.pop_front();
        m_last_vld = 1'b1;
      end
      if (din_valid && din_ready) sb_q.push_back(gray(din));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    m_last = '0; m_last_vld = 1'b0; post_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step_cyc(4'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_ready", 32'(din_ready), 32'd1);
`ifdef BIN2GRAY_PARITY_EN
    chk("rst_parity", 32'(dout_parity), 32'd0);
`endif

    // First word: 5 -> 0111, no prior transfer so no step
    step_cyc(4'd5, 1'b1, 1'b1, 1'b0);
    chk("first_dout", 32'(dout), 32'h7);
    chk("first_step", 32'(dout_step), 32'd0);

    // Back-to-back 0..15,0 including the 1000 -> 0000 wrap
    for (int i = 0; i < 16; i++) step_cyc(4'(i), 1'b1, 1'b1, 1'b0);
    chk("f_dout", 32'(dout), 32'h8);
`ifdef BIN2GRAY_PARITY_EN
    chk("f_parity", 32'(dout_parity), 32'd1);
`endif
    step_cyc(4'd0, 1'b1, 1'b1, 1'b0);
    chk("wrap_dout", 32'(dout), 32'h0);
    chk("wrap_step", 32'(dout_step), 32'd1);
    repeat (2) step_cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // Stall: 6 then 3 fill OUT and SKD, ready drops, order preserved on release
    step_cyc(4'd6, 1'b1, 1'b0, 1'b0);
`ifdef BIN2GRAY_PARITY_EN
    chk("six_parity", 32'(dout_parity), 32'd0);
`endif
    step_cyc(4'd3, 1'b1, 1'b0, 1'b0);
    chk("full_dout", 32'(dout), 32'h5);
    chk("full_ready", 32'(din_ready), 32'd0);
    step_cyc(4'd9, 1'b1, 1'b0, 1'b0);
    chk("hold_dout", 32'(dout), 32'h5);
    step_cyc(4'd0, 1'b0, 1'b1, 1'b0);
    chk("skd_dout", 32'(dout), 32'h2);
    chk("skd_ready", 32'(din_ready), 32'd1);
    step_cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // Multi-bit and equal consecutive codes give no step
    step_cyc(4'd0, 1'b1, 1'b1, 1'b0);
    step_cyc(4'd5, 1'b1, 1'b1, 1'b0);
    chk("multi_step", 32'(dout_step), 32'd0);
    step_cyc(4'd5, 1'b1, 1'b1, 1'b0);
    chk("equal_step", 32'(dout_step), 32'd0);
    step_cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // Reset while FULL with a handshake pending
    step_cyc(4'd9, 1'b1, 1'b0, 1'b0);
    step_cyc(4'd10, 1'b1, 1'b0, 1'b0);
    step_cyc(4'd11, 1'b1, 1'b1, 1'b1);
    chk("mrst_valid", 32'(dout_valid), 32'd0);
    chk("mrst_ready", 32'(din_ready), 32'd1);
    chk("mrst_dout", 32'(dout), 32'd0);
    step_cyc(4'd2, 1'b1, 1'b1, 1'b0);
    chk("fresh_dout", 32'(dout), 32'h3);
    chk("fresh_step", 32'(dout_step), 32'd0);

    // Random traffic with random backpressure, including small binary increments
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = (i % 3 == 0) ? 4'($urandom_range(15)) : 4'(m_last + 4'(i % 2));
      step_cyc(d, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    end
    for (int i = 0; i < 4; i++) step_cyc(4'd0, 1'b0, 1'b1, 1'b0);
    chk("drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
